// File: rtl/mdu_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mdu_pkg;

  // Default datapath width (HI and LO are each this wide)
  localparam int MDU_WIDTH = 32;

  // Operation encodings on the op port; 6 and 7 are reserved
  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  // Quotient reported for a divide by zero
  localparam logic [MDU_WIDTH-1:0] DIV0_LO = '1;

  // Engine sequencing states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring shift-subtract divide step (one quotient bit).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
import mdu_pkg::*;

module mdu_div_step #(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Shift the next dividend bit (held in quo's MSB) into the remainder and
  // keep the difference only if it did not go negative.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    if (shifted >= {1'b0, dvs}) begin
      rem_nxt = diff[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MULT/MULTU/DIV/DIVU engine writing HI/LO; MTHI/MTLO write directly.
// Latency: WIDTH+1 cycles start-to-done (1 cycle for multiplies with MDU_FAST_MUL_EN).
// Backpressure: busy high while running; start is dropped, not queued, while busy.
// Build option: define MDU_FAST_MUL_EN for a single-cycle multiplier path.
import mdu_pkg::*;

module mdu_iter #(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 5            // must equal clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t state, state_n;

  logic [CNT_W-1:0]   cnt;
  logic               is_div;     // latched op class: 1 = divide, 0 = multiply
  logic               neg_q;      // negate product / quotient at FIX
  logic               neg_r;      // negate remainder at FIX (dividend sign)
  logic               b_zero;     // divisor was zero
  logic [WIDTH-1:0]   a_sav;      // original dividend for the divide-by-zero result
  logic [WIDTH-1:0]   bv;         // multiplicand / divisor magnitude
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits then quotient bits}.
  logic [2*WIDTH-1:0] acc;

  logic               sgn_op, sa, sb, fast_path;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] acc_init;

  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH-1:0]   rem_nxt, quo_nxt;
  logic [2*WIDTH-1:0] step_nxt;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign busy = (state != ST_IDLE);

  // Operand decode: signs and magnitudes for the signed ops, starting accumulator
  always_comb begin
    sgn_op = (op == OP_MULT) || (op == OP_DIV);
    sa     = sgn_op & a[WIDTH-1];
    sb     = sgn_op & b[WIDTH-1];
    abs_a  = sa ? (WIDTH'(0) - a) : a;
    abs_b  = sb ? (WIDTH'(0) - b) : b;
`ifdef MDU_FAST_MUL_EN
    fast_path = !op[1];
    acc_init  = fast_path ? ({{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b})
                          : {{WIDTH{1'b0}}, abs_a};
`else
    fast_path = 1'b0;
    acc_init  = {{WIDTH{1'b0}}, abs_a};
`endif
  end

  // One iteration: add-then-shift for multiply, restoring step for divide
  always_comb begin
    msum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? bv : {WIDTH{1'b0}})};
    mul_nxt  = {msum, acc[WIDTH-1:1]};
    step_nxt = is_div ? {rem_nxt, quo_nxt} : mul_nxt;
  end

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem     (acc[2*WIDTH-1:WIDTH]),
    .quo     (acc[WIDTH-1:0]),
    .dvs     (bv),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // Sign correction of the magnitude result; divide by zero overrides it.
  // DIV0_LO is sign-extended so the quotient stays all-ones at any WIDTH.
  always_comb begin
    prod_fix = neg_q ? ((2*WIDTH)'(0) - acc) : acc;
    quo_fix  = neg_q ? (WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem_fix  = neg_r ? (WIDTH'(0) - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    if (b_zero) begin
      quo_fix = WIDTH'(signed'(DIV0_LO));
      rem_fix = a_sav;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state: CALC runs exactly WIDTH edges, FIX is a single edge
  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (start && !op[2]) state_n = fast_path ? ST_FIX : ST_CALC;
      ST_CALC: if (cnt == CNT_W'(WIDTH-1)) state_n = ST_FIX;
      ST_FIX:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, HI/LO write-back and done pulse
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      a_sav  <= '0;
      bv     <= '0;
      acc    <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end else if (!op[2]) begin
              is_div <= op[1];
              neg_q  <= sa ^ sb;
              neg_r  <= sa;
              b_zero <= (b == '0);
              a_sav  <= a;
              bv     <= abs_b;
              acc    <= acc_init;
              cnt    <= '0;
            end
          end
        end
        ST_CALC: begin
          acc <= step_nxt;
          cnt <= cnt + CNT_W'(1);
        end
        ST_FIX: begin
          done <= 1'b1;
          cnt  <= '0;
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Randomized and directed checks of mdu_iter against an arithmetic reference model.
// Latency: expected start-to-done is 33 edges (1 for multiplies with MDU_FAST_MUL_EN).
// Backpressure: starts issued while busy must be dropped.
module tb_mdu_iter;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;

  mdu_iter dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: {hi, lo} from plain 64-bit arithmetic
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    u  = '0;
    case (o)
      3'd0: begin q = sx * sy; u = q; end
      3'd1: u = {32'd0, x} * {32'd0, y};
      3'd2: begin
        if (y == 0) u = {x, 32'hFFFF_FFFF};
        else begin q = sx / sy; r = sx % sy; u = {r[31:0], q[31:0]}; end
      end
      3'd3: begin
        if (y == 0) u = {x, 32'hFFFF_FFFF};
        else begin u[31:0] = x / y; u[63:32] = x % y; end
      end
      default: u = '0;
    endcase
    return u;
  endfunction

  function automatic int lat_exp(input logic [2:0] o);
`ifdef MDU_FAST_MUL_EN
    return (o < 3'd2) ? 1 : 33;
`else
    return (o == 3'd0) ? 33 : 33;
`endif
  endfunction

  // Issue one op at the current cycle and wait (bounded) for done
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] rh, output logic [31:0] rl,
                       output int lat, output int bcnt);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
    bcnt = int'(busy);
    lat  = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
    rh = hi; rl = lo;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    n_cmp++; if (hi !== 32'd0)  begin n_bad++; $display("FAIL reset_hi got %h want 0", hi); end
    n_cmp++; if (lo !== 32'd0)  begin n_bad++; $display("FAIL reset_lo got %h want 0", lo); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_reserved();
    for (int i = 6; i < 8; i++) begin
      start = 1'b1; op = 3'(i); a = $urandom | 32'h1; b = $urandom;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      n_cmp++; if ({hi, lo} !== 64'd0) begin n_bad++; $display("FAIL rsvd_op%0d hilo got %h want 0", i, {hi, lo}); end
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rsvd_op%0d busy/done got %b%b want 00", i, busy, done); end
    end
  endtask

  task automatic test_directed();
    logic [2:0]  t_op [5] = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd2};
    logic [31:0] t_a  [5] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000};
    logic [31:0] t_b  [5] = '{32'd2, 32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] rh, rl;
    logic [63:0] exp;
    int lat, bcnt;
    for (int i = 0; i < 5; i++) begin
      exp = ref_model(t_op[i], t_a[i], t_b[i]);
      do_op(t_op[i], t_a[i], t_b[i], rh, rl, lat, bcnt);
      n_cmp++; if (rh !== exp[63:32]) begin n_bad++; $display("FAIL dir%0d_hi got %h want %h", i, rh, exp[63:32]); end
      n_cmp++; if (rl !== exp[31:0])  begin n_bad++; $display("FAIL dir%0d_lo got %h want %h", i, rl, exp[31:0]); end
      n_cmp++; if (lat !== lat_exp(t_op[i])) begin n_bad++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, lat_exp(t_op[i])); end
      n_cmp++; if (bcnt !== lat_exp(t_op[i])) begin n_bad++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bcnt, lat_exp(t_op[i])); end
      @(posedge clk); #1;
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL dir%0d_done_width got %b want 0", i, done); end
    end
  endtask

  task automatic test_mt();
    start = 1'b1; op = 3'd4; a = 32'h1234;
    @(posedge clk); #1;
    n_cmp++; if (hi !== 32'h1234) begin n_bad++; $display("FAIL mthi got %h want 00001234", hi); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL mthi_busy_done got %b%b want 00", busy, done); end
    op = 3'd5; a = 32'h5678;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++; if (lo !== 32'h5678 || hi !== 32'h1234) begin n_bad++; $display("FAIL mtlo got hi=%h lo=%h want 00001234/00005678", hi, lo); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL mtlo_busy_done got %b%b want 00", busy, done); end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] h0, l0;
    logic [63:0] exp;
    logic stable;
    int lat, extra;
    exp = ref_model(3'd3, 32'd1000, 32'd7);
    h0 = hi; l0 = lo; stable = 1'b1;
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == 5) begin start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd5; end
      else start = 1'b0;
      if (hi !== h0 || lo !== l0) stable = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    n_cmp++; if (stable !== 1'b1) begin n_bad++; $display("FAIL busy_hilo_stable got %b want 1", stable); end
    n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL busy_latency got %0d want 33", lat); end
    n_cmp++; if ({hi, lo} !== exp) begin n_bad++; $display("FAIL busy_divu_result got %h want %h", {hi, lo}, exp); end
    extra = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) extra++; end
    n_cmp++; if (extra !== 0) begin n_bad++; $display("FAIL busy_dropped_start got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rh, rl;
    logic [63:0] exp;
    int lat, bcnt, seen;
    start = 1'b1; op = 3'd0; a = 32'h0001_2345; b = 32'h0000_0ABC;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", busy); end
    n_cmp++; if ({hi, lo} !== 64'd0) begin n_bad++; $display("FAIL abort_hilo got %h want 0", {hi, lo}); end
    seen = int'(done);
    repeat (40) begin @(posedge clk); #1; if (done) seen++; end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_done_pulses got %0d want 0", seen); end
    exp = ref_model(3'd0, 32'hFFFF_FFFD, 32'd4);
    do_op(3'd0, 32'hFFFF_FFFD, 32'd4, rh, rl, lat, bcnt);
    n_cmp++; if ({rh, rl} !== exp) begin n_bad++; $display("FAIL abort_fresh_mult got %h want %h", {rh, rl}, exp); end
    n_cmp++; if (lat !== lat_exp(3'd0)) begin n_bad++; $display("FAIL abort_fresh_latency got %0d want %0d", lat, lat_exp(3'd0)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rh, rl, x, y;
    logic [63:0] exp;
    logic [2:0]  o;
    int lat, bcnt;
    for (int i = 0; i < 4; i++) begin
      o = 3'(i); x = $urandom; y = $urandom_range(1, 1000);
      exp = ref_model(o, x, y);
      do_op(o, x, y, rh, rl, lat, bcnt);   // next iteration starts in the done cycle
      n_cmp++; if ({rh, rl} !== exp) begin n_bad++; $display("FAIL b2b%0d_result got %h want %h", i, {rh, rl}, exp); end
      n_cmp++; if (lat !== lat_exp(o)) begin n_bad++; $display("FAIL b2b%0d_latency got %0d want %0d", i, lat, lat_exp(o)); end
    end
  endtask

  task automatic test_random();
    logic [31:0] rh, rl, x, y;
    logic [63:0] exp;
    logic [2:0]  o;
    int lat, bcnt, sel;
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       y = 32'd0;
        1, 2:    y = $urandom_range(1, 20);
        3:       begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        4:       y = 32'hFFFF_FFFF - $urandom_range(0, 5);
        default: y = $urandom;
      endcase
      exp = ref_model(o, x, y);
      do_op(o, x, y, rh, rl, lat, bcnt);
      n_cmp++; if ({rh, rl} !== exp) begin n_bad++; $display("FAIL rnd%0d_op%0d a=%h b=%h got %h want %h", i, o, x, y, {rh, rl}, exp); end
      n_cmp++; if (lat !== lat_exp(o)) begin n_bad++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, lat_exp(o)); end
    end
  endtask

  initial begin
    test_reset();
    test_reserved();
    test_directed();
    test_mt();
    test_busy_ignore();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
